// File: rtl/gpio_count_monitor_if.sv
// gpio_count_monitor_if: pad sample/enable inputs and result outputs of the GPIO count monitor
interface gpio_count_monitor_if #(parameter int WIDTH = 8);
  logic             enable;
  logic [WIDTH-1:0] gpio_in;
  logic [2:0]       state;
  logic             pass;
  logic             fail;
  logic [1:0]       err_code;
  logic [WIDTH-1:0] last_value;
  logic [15:0]      step_count;
  logic             acc_strobe;
  modport master (output enable, gpio_in,
                  input state, pass, fail, err_code, last_value, step_count, acc_strobe);
  modport slave  (input enable, gpio_in,
                  output state, pass, fail, err_code, last_value, step_count, acc_strobe);
endinterface

// File: rtl/gpio_count_monitor.sv
// gpio_count_monitor: checks that a synced, debounced GPIO slice counts START_VAL..END_VAL by +1
module gpio_count_monitor #(
  parameter int               WIDTH          = 8,
  parameter logic [WIDTH-1:0] START_VAL      = 8'd0,
  parameter logic [WIDTH-1:0] END_VAL        = 8'd33,
  parameter int               STABLE_CYCLES  = 4,
  parameter int               TIMEOUT_CYCLES = 24000
) (
  input logic clock,
  input logic reset,
  gpio_count_monitor_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, WAIT_START, TRACK, PASS, FAIL} state_e;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] s1_q, s2_q, cand_q, acc_q, acc_d, last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WW-1:0]    wd_q, wd_d;
  logic [15:0]      step_q, step_d;
  logic [1:0]       err_q, err_d;
  logic             first_q, first_d, strobe_q, accept, expired;
  // first_q forces the pad value present at enable to be accepted even if unchanged
  assign accept  = state_q != IDLE && bus.enable && s2_q == cand_q &&
                   cnt_q >= CW'(STABLE_CYCLES - 1) && (cand_q != acc_q || first_q);
  assign cnt_d   = s2_q != cand_q ? CW'(1) : (cnt_q == CW'(STABLE_CYCLES) ? cnt_q : cnt_q + CW'(1));
  assign acc_d   = accept ? cand_q : acc_q;
  assign first_d = state_q == IDLE ? 1'b1 : (accept ? 1'b0 : first_q);
  assign expired = wd_q == WW'(TIMEOUT_CYCLES);
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    step_d  = step_q;
    err_d   = err_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE: begin
        state_d = WAIT_START;
        wd_d    = '0;
      end
      WAIT_START: begin
        wd_d = strobe_q ? '0 : wd_q + WW'(1);
        if (strobe_q && acc_q == START_VAL) begin
          state_d = START_VAL == END_VAL ? PASS : TRACK;
          last_d  = START_VAL;
          step_d  = '0;
        end else if (!strobe_q && expired) begin
          state_d = FAIL;
          err_d   = 2'd3;
        end
      end
      TRACK: begin
        wd_d = strobe_q ? '0 : wd_q + WW'(1);
        if (strobe_q && acc_q == last_q + WIDTH'(1)) begin
          last_d  = acc_q;
          step_d  = step_q == 16'hFFFF ? step_q : step_q + 16'd1;
          state_d = acc_q == END_VAL ? PASS : TRACK;
        end else if (strobe_q) begin
          state_d = FAIL;
          err_d   = 2'd1;
        end else if (expired) begin
          state_d = FAIL;
          err_d   = 2'd2;
        end
      end
      default: ;
    endcase
    if (!bus.enable) begin
      state_d = IDLE;
      last_d  = '0;
      step_d  = '0;
      err_d   = '0;
      wd_d    = '0;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      first_q  <= 1'b0;
      strobe_q <= 1'b0;
      state_q  <= IDLE;
      last_q   <= '0;
      step_q   <= '0;
      err_q    <= '0;
      wd_q     <= '0;
    end else begin
      s1_q     <= bus.gpio_in;
      s2_q     <= s1_q;
      cand_q   <= s2_q;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      first_q  <= first_d;
      strobe_q <= accept;
      state_q  <= state_d;
      last_q   <= last_d;
      step_q   <= step_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
    end
  end
  assign bus.state      = state_q;
  assign bus.pass       = state_q == PASS;
  assign bus.fail       = state_q == FAIL;
  assign bus.err_code   = err_q;
  assign bus.last_value = last_q;
  assign bus.step_count = step_q;
  assign bus.acc_strobe = strobe_q;
endmodule

// File: tb/tb_gpio_count_monitor.sv
// tb_gpio_count_monitor: scoreboard bench; expected last_value/step_count queued per driven value
module tb_gpio_count_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  gpio_count_monitor_if #(.WIDTH(8)) ia ();
  gpio_count_monitor_if #(.WIDTH(8)) ib ();
  gpio_count_monitor dut_a (.clock(clk), .reset(rst), .bus(ia.slave));
  gpio_count_monitor #(.START_VAL(8'd254), .END_VAL(8'd2)) dut_b (.clock(clk), .reset(rst), .bus(ib.slave));
  typedef struct packed {logic [7:0] last; logic [15:0] step;} exp_t;
  exp_t q[$];
  exp_t e;
  int vectors = 0, miscompares = 0;
  logic sel = 1'b0, pend = 1'b0;
  int mode, m_err, n;
  logic [7:0] m_last, m_start, m_end;
  logic [15:0] m_step;
  wire [2:0]  state_m  = sel ? ib.state : ia.state;
  wire        pass_m   = sel ? ib.pass : ia.pass;
  wire        fail_m   = sel ? ib.fail : ia.fail;
  wire [1:0]  err_m    = sel ? ib.err_code : ia.err_code;
  wire [7:0]  last_m   = sel ? ib.last_value : ia.last_value;
  wire [15:0] step_m   = sel ? ib.step_count : ia.step_count;
  wire        strobe_m = sel ? ib.acc_strobe : ia.acc_strobe;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // last_value/step_count settle one cycle after each acceptance strobe
  always @(negedge clk) begin
    if (pend) begin
      if (q.size() == 0) chk("sb_unexpected_strobe", 1, 0);
      else begin
        e = q.pop_front();
        chk("sb_last", last_m, e.last);
        chk("sb_step", step_m, e.step);
      end
      pend = 1'b0;
    end
    if (strobe_m) pend = 1'b1;
  end
  task automatic model(input logic [7:0] v);
    if (mode == 0 && v == m_start) begin
      m_last = v;
      m_step = 0;
      mode = (m_start == m_end) ? 2 : 1;
    end else if (mode == 1) begin
      if (v == 8'(m_last + 8'd1)) begin
        m_last = v;
        m_step++;
        if (v == m_end) mode = 2;
      end else begin
        mode = 3;
        m_err = 1;
      end
    end
    q.push_back(exp_t'{last: m_last, step: m_step});
  endtask
  task automatic drive(input logic [7:0] v);
    if (sel) ib.gpio_in = v; else ia.gpio_in = v;
  endtask
  task automatic put(input logic [7:0] v, input int hold);
    drive(v);
    model(v);
    repeat (hold) @(negedge clk);
  endtask
  task automatic start_run(input logic s, input logic [7:0] st, input logic [7:0] en, input logic [7:0] v);
    sel = s;
    m_start = st;
    m_end = en;
    mode = 0;
    m_err = 0;
    m_last = 0;
    m_step = 0;
    drive(v);
    repeat (10) @(negedge clk);
    if (s) ib.enable = 1'b1; else ia.enable = 1'b1;
    model(v);
    repeat (20) @(negedge clk);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_state"}, state_m, 0);
    chk({tag, "_pass"}, pass_m, 0);
    chk({tag, "_fail"}, fail_m, 0);
    chk({tag, "_err"}, err_m, 0);
    chk({tag, "_last"}, last_m, 0);
    chk({tag, "_step"}, step_m, 0);
    chk({tag, "_strobe"}, strobe_m, 0);
  endtask
  task automatic stop_run(input string tag);
    if (sel) ib.enable = 1'b0; else ia.enable = 1'b0;
    repeat (2) @(negedge clk);
    check_zero(tag);
    chk({tag, "_sb_drained"}, q.size(), 0);
    q.delete();
  endtask
  task automatic expect_end(input string tag);
    repeat (2) @(negedge clk);
    chk({tag, "_state"}, state_m, mode + 1);
    chk({tag, "_pass"}, pass_m, mode == 2);
    chk({tag, "_fail"}, fail_m, mode == 3);
    chk({tag, "_err"}, err_m, m_err);
    chk({tag, "_last"}, last_m, m_last);
    chk({tag, "_step"}, step_m, m_step);
  endtask
  task automatic wait_fail(input int max, output int cnt);
    cnt = 0;
    while (fail_m !== 1'b1 && cnt < max) begin
      @(negedge clk);
      cnt++;
    end
  endtask
  initial begin
    ia.enable = 1'b0;
    ib.enable = 1'b0;
    ia.gpio_in = 8'h00;
    ib.gpio_in = 8'h00;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("idle");
    // full count with long holds, then disable clears everything
    start_run(1'b0, 8'd0, 8'd33, 8'd0);
    for (int i = 1; i <= 33; i++) put(8'(i), 100);
    expect_end("t1_pass");
    stop_run("t1_disable");
    // skip 5 -> 7
    start_run(1'b0, 8'd0, 8'd33, 8'd0);
    for (int i = 1; i <= 5; i++) put(8'(i), 20);
    put(8'd7, 20);
    expect_end("t2_skip");
    repeat (50) @(negedge clk);
    chk("t2_sticky", state_m, 4);
    stop_run("t2_disable");
    // short glitch between 3 and 4 must not be accepted
    start_run(1'b0, 8'd0, 8'd33, 8'd0);
    for (int i = 1; i <= 33; i++) begin
      if (i == 4) begin
        drive(8'hFF);
        repeat (2) @(negedge clk);
      end
      put(8'(i), 20);
    end
    expect_end("t3_glitch");
    stop_run("t3_disable");
    // stall at 9
    start_run(1'b0, 8'd0, 8'd33, 8'd0);
    for (int i = 1; i <= 9; i++) put(8'(i), 20);
    wait_fail(25000, n);
    mode = 3;
    m_err = 2;
    chk("t4_stall_not_early", n > 23900, 1);
    expect_end("t4_stall");
    stop_run("t4_disable");
    // START never seen
    start_run(1'b0, 8'd0, 8'd33, 8'h55);
    wait_fail(25000, n);
    mode = 3;
    m_err = 3;
    chk("t4_nostart_not_early", n > 23900, 1);
    expect_end("t4_nostart");
    stop_run("t4b_disable");
    // wrap-around sequence on the second instance
    start_run(1'b1, 8'd254, 8'd2, 8'd254);
    put(8'd255, 20);
    put(8'd0, 20);
    put(8'd1, 20);
    put(8'd2, 20);
    expect_end("t5_wrap");
    stop_run("t5_disable");
    // asynchronous reset in the middle of tracking
    start_run(1'b0, 8'd0, 8'd33, 8'd0);
    for (int i = 1; i <= 12; i++) put(8'(i), 20);
    chk("t6_last_before", last_m, 12);
    chk("t6_state_before", state_m, 2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    ia.enable = 1'b0;
    #1;
    check_zero("t6_async");
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    repeat (3) @(negedge clk);
    check_zero("t6_after");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
